// File: rtl/ram_pipelined_pkg.sv
// rtl/ram_pipelined_pkg.sv - shared defaults and pipeline stage type for the pipelined data RAM
//
// Purpose: default geometry of the data RAM and the per-stage control flags that
//          travel down the response pipeline alongside the read data.
// Ports:   none (package).

package ram_pipelined_pkg;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_ADDR_WIDTH   = 32;
  localparam int DEF_DEPTH_LOG2   = 14;
  localparam int DEF_READ_LATENCY = 1;

  // Control flags carried by every pipeline stage.
  //   valid : a response occupies this stage
  //   error : the request fell outside the RAM window
  //   read  : bank read data is meaningful (in-range read); otherwise data is forced to 0
  typedef struct packed {
    logic valid;
    logic error;
    logic read;
  } stage_t;

  function automatic stage_t make_stage(input logic accept, input logic in_range,
                                        input logic is_write);
    stage_t s;
    s.valid = accept;
    s.error = accept && !in_range;
    s.read  = accept && in_range && !is_write;
    return s;
  endfunction

endpackage

// File: rtl/ram_pipelined_if.sv
// rtl/ram_pipelined_if.sv - request/response channel bundle of the pipelined data RAM
//
// Purpose: valid/ready request channel plus in-order valid/ready response channel.
// Signals:
//   req_valid, req_ready            request handshake
//   req_write_en   [LANES]          byte-lane write enables, all zero = read
//   req_addr       [ADDR_WIDTH]     byte address
//   req_write_data [DATA_WIDTH]     write data, lane i = bits [8i+7:8i]
//   resp_valid, resp_ready          response handshake
//   resp_read_data [DATA_WIDTH]     read data, 0 for writes and errors
//   resp_error                      request address outside the RAM window
// Modports: master (requester side), slave (RAM side).

interface ram_pipelined_if #(
  parameter int DATA_WIDTH = ram_pipelined_pkg::DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = ram_pipelined_pkg::DEF_ADDR_WIDTH
);
  localparam int LANES = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic [LANES-1:0]      req_write_en;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_write_data;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_read_data;
  logic                  resp_error;

  modport master (
    output req_valid, req_write_en, req_addr, req_write_data, resp_ready,
    input  req_ready, resp_valid, resp_read_data, resp_error
  );

  modport slave (
    input  req_valid, req_write_en, req_addr, req_write_data, resp_ready,
    output req_ready, resp_valid, resp_read_data, resp_error
  );

endinterface

// File: rtl/ram_byte_bank.sv
// rtl/ram_byte_bank.sv - one 8-bit synchronous RAM bank, one byte lane of the data RAM
//
// Purpose: 8-bit x 2^DEPTH_LOG2 storage with synchronous write and registered read.
// Ports:
//   clk      clock
//   wr_en    write wr_data to addr on this edge
//   rd_en    capture mem[addr] into rd_data on this edge; rd_data holds when low
//   addr     word index
//   wr_data  byte to write
//   rd_data  registered read byte

module ram_byte_bank #(
  parameter int DEPTH_LOG2 = ram_pipelined_pkg::DEF_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [7:0]            wr_data,
  output logic [7:0]            rd_data
);

  logic [7:0] mem [0:(1 << DEPTH_LOG2)-1];

  // Storage is deliberately not reset. Holding rd_data while rd_en is low is what
  // keeps a stalled response stable without re-reading the array.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_pipelined.sv
// rtl/ram_pipelined.sv - byte-lane data RAM with valid/ready request and in-order response pipeline
//
// Purpose: one request per cycle, READ_LATENCY (1 or 2) cycles to response, backpressure
//          holds the whole pipeline; out-of-window addresses return resp_error instead of aliasing.
// Ports:
//   clk     clock, all state on the rising edge
//   rst_n   asynchronous active-low reset
//   bus     ram_pipelined_if.slave: req_* request channel, resp_* response channel

module ram_pipelined
  import ram_pipelined_pkg::*;
#(
  parameter int                    DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int                    ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int                    DEPTH_LOG2   = DEF_DEPTH_LOG2,
  parameter int                    READ_LATENCY = DEF_READ_LATENCY,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_pipelined_if.slave    bus
);

  localparam int LANES     = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(LANES);
  localparam int SPAN_BITS = LANE_BITS + DEPTH_LOG2;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("ram_pipelined: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("ram_pipelined: DATA_WIDTH must be a multiple of 8");
  end

  logic                  stall;
  logic                  accept;
  logic                  is_write;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] offset;
  logic [DEPTH_LOG2-1:0] index;
  logic [DATA_WIDTH-1:0] bank_rd;
  stage_t                s1;
  logic [DATA_WIDTH-1:0] s1_data;

  // Only resp_ready (and reset) reach req_ready combinationally.
  assign stall         = bus.resp_valid && !bus.resp_ready;
  assign bus.req_ready = rst_n && !stall;
  assign accept        = bus.req_valid && bus.req_ready;
  assign is_write      = |bus.req_write_en;

  // Window check: below BASE_ADDR fails the compare; at or above the top, the
  // offset has bits set above the word-index field.
  assign offset   = bus.req_addr - BASE_ADDR;
  assign in_range = (bus.req_addr >= BASE_ADDR) && ((offset >> SPAN_BITS) == '0);
  assign index    = offset[LANE_BITS +: DEPTH_LOG2];

  // Banks only see enables on an accepted request, so nothing commits or
  // re-reads while stalled.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    ram_byte_bank #(.DEPTH_LOG2(DEPTH_LOG2)) u_bank (
      .clk     (clk),
      .wr_en   (accept && in_range && bus.req_write_en[l]),
      .rd_en   (accept && in_range && !is_write),
      .addr    (index),
      .wr_data (bus.req_write_data[8*l +: 8]),
      .rd_data (bank_rd[8*l +: 8])
    );
  end

  // Stage 1 lines up with the bank's registered read output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
    end else if (!stall) begin
      s1 <= make_stage(accept, in_range, is_write);
    end
  end

  // Bank output is uninitialised after reset and meaningless for writes/errors.
  assign s1_data = s1.read ? bank_rd : '0;

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s2_valid;
    logic                  s2_error;
    logic [DATA_WIDTH-1:0] s2_data;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid <= 1'b0;
        s2_error <= 1'b0;
        s2_data  <= '0;
      end else if (!stall) begin
        s2_valid <= s1.valid;
        s2_error <= s1.error;
        s2_data  <= s1_data;
      end
    end

    assign bus.resp_valid     = s2_valid;
    assign bus.resp_error     = s2_error;
    assign bus.resp_read_data = s2_data;
  end else begin : g_lat1
    assign bus.resp_valid     = s1.valid;
    assign bus.resp_error     = s1.error;
    assign bus.resp_read_data = s1_data;
  end

endmodule

// File: tb/tb_ram_pipelined.sv
// tb/tb_ram_pipelined.sv - self-checking bench for ram_pipelined at read latency 1 and 2

module tb_ram_pipelined;

  localparam int          DW    = 32;
  localparam int          AW    = 32;
  localparam int          DL    = 8;
  localparam int          WORDS = 1 << DL;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] TOP   = BASE + 32'(4 * WORDS);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [3:0]  req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;
  int          sel;

  always #5 clk = ~clk;

  ram_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
  ram_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

  assign bus1.req_valid      = req_valid && (sel == 0);
  assign bus1.req_write_en   = req_we;
  assign bus1.req_addr       = req_addr;
  assign bus1.req_write_data = req_wdata;
  assign bus1.resp_ready     = (sel == 0) ? resp_ready : 1'b1;
  assign bus2.req_valid      = req_valid && (sel == 1);
  assign bus2.req_write_en   = req_we;
  assign bus2.req_addr       = req_addr;
  assign bus2.req_write_data = req_wdata;
  assign bus2.resp_ready     = (sel == 1) ? resp_ready : 1'b1;

  ram_pipelined #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL), .READ_LATENCY(1),
                  .BASE_ADDR(BASE)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  ram_pipelined #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL), .READ_LATENCY(2),
                  .BASE_ADDR(BASE)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic        o_req_ready, o_resp_valid, o_resp_error;
  logic [31:0] o_resp_data;
  assign o_req_ready  = (sel == 0) ? bus1.req_ready      : bus2.req_ready;
  assign o_resp_valid = (sel == 0) ? bus1.resp_valid     : bus2.resp_valid;
  assign o_resp_error = (sel == 0) ? bus1.resp_error     : bus2.resp_error;
  assign o_resp_data  = (sel == 0) ? bus1.resp_read_data : bus2.resp_read_data;

  // Reference model: word array plus expected-response queue with accept times.
  logic [31:0] ref_mem [WORDS];
  logic [31:0] q_data[$];
  logic        q_err[$];
  int          q_acc[$];
  int          q_st[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc = 0;
  int          stall_cnt = 0;
  bit          prev_stall = 0;
  bit          accepted = 0;
  bit          hold_ready_low = 0;
  logic [31:0] last_data;
  logic        last_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s (latency %0d): observed %h expected %h", tag, sel + 1, obs, exp_v);
    end
  endtask

  task automatic model_accept();
    bit          inr;
    int          idx;
    logic [31:0] w;
    inr = (req_addr >= BASE) && (req_addr < TOP);
    idx = inr ? int'((req_addr - BASE) / 4) : 0;
    if (req_we != 4'b0) begin
      if (inr) begin
        w = ref_mem[idx];
        for (int b = 0; b < 4; b++)
          if (req_we[b]) w[8*b +: 8] = req_wdata[8*b +: 8];
        ref_mem[idx] = w;
      end
      q_data.push_back(32'h0);
    end else begin
      q_data.push_back(inr ? ref_mem[idx] : 32'h0);
    end
    q_err.push_back(!inr);
    q_acc.push_back(cyc);
    q_st.push_back(stall_cnt);
  endtask

  // One clock: observe both channels, update the model, advance to posedge+1.
  // Each response is due READ_LATENCY cycles after its accept plus every stalled cycle in between.
  task automatic step();
    #1;
    if (o_resp_valid === 1'b1) begin
      if (q_data.size() == 0) begin
        chk("spurious_resp", 32'd1, 32'd0);
      end else begin
        chk("resp_data", o_resp_data, q_data[0]);
        chk("resp_error", 32'(o_resp_error), 32'(q_err[0]));
        if (resp_ready) begin
          chk("resp_latency", 32'(cyc), 32'(q_acc[0] + sel + 1 + (stall_cnt - q_st[0])));
          last_data = o_resp_data;
          last_err  = o_resp_error;
          void'(q_data.pop_front());
          void'(q_err.pop_front());
          void'(q_acc.pop_front());
          void'(q_st.pop_front());
        end
      end
    end
    if (prev_stall) chk("held_valid", 32'(o_resp_valid), 32'd1);
    if (hold_ready_low) chk("stall_req_ready", 32'(o_req_ready), 32'd0);
    accepted = req_valid && (o_req_ready === 1'b1);
    if (accepted) model_accept();
    prev_stall = (o_resp_valid === 1'b1) && !resp_ready;
    if (prev_stall) stall_cnt++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    accepted  = 0;
    for (int i = 0; i < 40 && !accepted; i++) step();
    if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 40 && q_data.size() != 0; i++) step();
    chk("drain_empty", 32'(q_data.size()), 32'd0);
    step();
    step();
  endtask

  initial begin
    rst_n = 1'b1;
    req_valid = 1'b0;
    req_we = 4'b0;
    req_addr = '0;
    req_wdata = '0;
    resp_ready = 1'b1;
    sel = 0;
    #1 rst_n = 1'b0;

    for (int s = 0; s < 2; s++) begin
      sel = s;
      // Reset with a request pending: nothing accepted, outputs quiet.
      rst_n = 1'b0;
      req_valid = 1'b1;
      req_addr = BASE;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk);
        #2;
        chk("reset_req_ready", 32'(o_req_ready), 32'd0);
        chk("reset_resp_valid", 32'(o_resp_valid), 32'd0);
        chk("reset_resp_data", o_resp_data, 32'd0);
      end
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      q_data.delete(); q_err.delete(); q_acc.delete(); q_st.delete();
      prev_stall = 0;

      // Fill the array so later reads have defined contents.
      for (int i = 0; i < WORDS; i++) send(4'hF, BASE + 32'(4 * i), $urandom);
      drain();

      // Full write then immediate read of the same word.
      send(4'hF, BASE + 32'h10, 32'hDEAD_BEEF);
      send(4'h0, BASE + 32'h10, 32'h0);
      drain();
      chk("write_read_data", last_data, 32'hDEAD_BEEF);

      // Partial lane write.
      send(4'b0101, BASE + 32'h10, 32'h1122_3344);
      send(4'h0, BASE + 32'h10, 32'h0);
      drain();
      chk("partial_merge", last_data, 32'hDE22_BE44);

      // Backpressure across a stream of four reads.
      send(4'h0, BASE + 32'h0, 32'h0);
      send(4'h0, BASE + 32'h4, 32'h0);
      resp_ready = 1'b0;
      req_valid = 1'b1;
      req_we = 4'h0;
      req_addr = BASE + 32'h8;
      hold_ready_low = 1;
      for (int i = 0; i < 5; i++) step();
      hold_ready_low = 0;
      resp_ready = 1'b1;
      send(4'h0, BASE + 32'h8, 32'h0);
      send(4'h0, BASE + 32'hC, 32'h0);
      drain();

      // Out-of-window write at the top and read below the base.
      send(4'hF, TOP, 32'h1234_5678);
      drain();
      chk("oor_top_error", 32'(last_err), 32'd1);
      send(4'h0, BASE - 32'h4, 32'h0);
      drain();
      chk("oor_below_error", 32'(last_err), 32'd1);
      chk("oor_below_data", last_data, 32'd0);
      send(4'h0, BASE, 32'h0);
      drain();

      // Randomised traffic with random backpressure.
      for (int i = 0; i < 300; i++) begin
        req_valid  = ($urandom_range(3, 0) != 0);
        resp_ready = ($urandom_range(9, 0) < 7);
        req_we     = ($urandom_range(1, 0) != 0) ? 4'(($urandom_range(15, 1))) : 4'h0;
        req_addr   = BASE - 32'h40 + 32'($urandom_range(4 * WORDS + 127, 0));
        req_wdata  = $urandom;
        step();
      end
      drain();

      // Reset while reads are in flight.
      send(4'hF, BASE + 32'h20, 32'hCAFE_F00D);
      send(4'h0, BASE + 32'h0, 32'h0);
      send(4'h0, BASE + 32'h4, 32'h0);
      #1;
      chk("pre_reset_valid", 32'(o_resp_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_valid", 32'(o_resp_valid), 32'd0);
      chk("async_reset_data", o_resp_data, 32'd0);
      chk("async_reset_ready", 32'(o_req_ready), 32'd0);
      q_data.delete(); q_err.delete(); q_acc.delete(); q_st.delete();
      prev_stall = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(4'h0, BASE + 32'h20, 32'h0);
      drain();
      chk("write_survives_reset", last_data, 32'hCAFE_F00D);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
